// File: rtl/key_event_sched.sv
// key_event_sched: round-robin four-key event scheduler driving a one-hot mode FSM and LED pattern; define KEY_SCHED_DROP_CNT_EN to add the drop_cnt output
module key_event_sched #(
  parameter int BLINK_DIV = 25000000,
  parameter int BLINK_W   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_flag,
  output logic [3:0] grant,
  output logic [3:0] state_o,
  output logic       hold_o,
  output logic [7:0] led
`ifdef KEY_SCHED_DROP_CNT_EN
  ,output logic [7:0] drop_cnt
`endif
);
  typedef enum logic [3:0] {IDLE = 4'b0001, ONE = 4'b0010, TWO = 4'b0100, THREE = 4'b1000} state_t;
  state_t state, state_nxt;
  logic [3:0] pending, gnt_nxt;
  logic [1:0] rr_ptr, ptr_nxt, idx;
  logic hold, hold_nxt, blink;
  logic [BLINK_W-1:0] blink_cnt;
  always_comb begin
    gnt_nxt = '0;
    ptr_nxt = rr_ptr;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = rr_ptr + 2'(k);
      if (pending[idx]) begin
        gnt_nxt = 4'b0001 << idx;
        ptr_nxt = idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      rr_ptr <= 2'd3;
      grant <= '0;
    end else begin
      pending <= (pending & ~gnt_nxt) | key_flag;
      rr_ptr <= ptr_nxt;
      grant <= gnt_nxt;
    end
  end
  // one-hot encoding makes NEXT/PREV plain rotations
  always_comb begin
    state_nxt = state;
    hold_nxt = hold;
    if (grant[3]) hold_nxt = ~hold;
    else if (!hold) begin
      if (grant[0]) state_nxt = state_t'({state[2:0], state[3]});
      else if (grant[1]) state_nxt = state_t'({state[0], state[3:1]});
      else if (grant[2]) state_nxt = IDLE;
    end
    if (!$onehot(state)) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold <= 1'b0;
      led <= '0;
    end else begin
      state <= state_nxt;
      hold <= hold_nxt;
      led <= {hold & blink, 4'b0, state == THREE, state == TWO, state == ONE};
    end
  end
  always_ff @(posedge clk) begin
    if (rst || !hold) begin
      blink_cnt <= '0;
      blink <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink <= ~blink;
    end else blink_cnt <= blink_cnt + 1'b1;
  end
  assign state_o = state;
  assign hold_o = hold;
`ifdef KEY_SCHED_DROP_CNT_EN
  logic [3:0] drop;
  logic [8:0] drop_sum;
  assign drop = key_flag & pending & ~gnt_nxt;
  assign drop_sum = {1'b0, drop_cnt} + 9'(drop[0]) + 9'(drop[1]) + 9'(drop[2]) + 9'(drop[3]);
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif
endmodule

// File: tb/tb_key_event_sched.sv
// tb_key_event_sched: table vectors, directed sequences and random traffic against a behavioural model
module tb_key_event_sched;
  localparam int DIV = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] key_flag = '0;
  logic [3:0] grant, state_o;
  logic hold_o;
  logic [7:0] led;
`ifdef KEY_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  always #5 clk = ~clk;
  key_event_sched #(.BLINK_DIV(DIV), .BLINK_W(3)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .grant(grant),
    .state_o(state_o), .hold_o(hold_o), .led(led)
`ifdef KEY_SCHED_DROP_CNT_EN
    ,.drop_cnt(drop_cnt)
`endif
  );
  int checks = 0, errors = 0;
  logic [3:0] m_pend, m_grant;
  int m_ptr, m_st, m_cnt, m_drop;
  logic m_hold, m_blink;
  logic [7:0] m_led;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // mode held as an index 0..3 (IDLE, ONE, TWO, THREE); arithmetic modulo 4
  task automatic model_step(input logic r, input logic [3:0] kf);
    logic [3:0] g;
    logic [7:0] l;
    int np;
    if (r) begin
      m_pend = 0; m_grant = 0; m_ptr = 3; m_st = 0; m_cnt = 0; m_drop = 0;
      m_hold = 0; m_blink = 0; m_led = 0;
      return;
    end
    g = 0;
    np = m_ptr;
    for (int k = 1; k <= 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (m_pend[i] && g == 0) begin
        g = 4'b0001 << i;
        np = i;
      end
    end
    for (int i = 0; i < 4; i++)
      if (kf[i] && m_pend[i] && !g[i]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    l = (m_st == 0) ? 8'h00 : 8'(1 << (m_st - 1));
    l[7] = m_hold & m_blink;
    m_led = l;
    if (!m_hold) begin
      m_cnt = 0; m_blink = 0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0; m_blink = !m_blink;
    end else m_cnt++;
    if (m_grant[3]) m_hold = !m_hold;
    else if (!m_hold) begin
      if (m_grant[0]) m_st = (m_st + 1) % 4;
      else if (m_grant[1]) m_st = (m_st + 3) % 4;
      else if (m_grant[2]) m_st = 0;
    end
    m_pend = (m_pend & ~g) | kf;
    m_grant = g;
    m_ptr = np;
  endtask
  task automatic step(input logic r, input logic [3:0] kf);
    rst = r;
    key_flag = kf;
    @(posedge clk);
    model_step(r, kf);
    #1;
    chk("model_grant", 32'(grant), 32'(m_grant));
    chk("model_state", 32'(state_o), 32'(4'b0001 << m_st));
    chk("model_hold", 32'(hold_o), 32'(m_hold));
    chk("model_led", 32'(led), 32'(m_led));
`ifdef KEY_SCHED_DROP_CNT_EN
    chk("model_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask
  typedef struct {
    logic r;
    logic [3:0] kf, g, st;
    logic h;
    logic [7:0] led;
  } vec_t;
  vec_t tbl[13];
  logic [3:0] nseq[4];
  initial begin
    int changes;
    logic prev;
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'h1, 4'h0, 4'h1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'h0, 4'h1, 4'h1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 8'h01};
    tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h1, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'h0, 4'h1, 4'h1, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 4'h0, 4'h2, 4'h2, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 4'h0, 4'h4, 4'h1, 1'b0, 8'h01};
    tbl[10] = '{1'b0, 4'h0, 4'h8, 4'h1, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 8'h00};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 8'h00};
    nseq = '{4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].kf);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_hold", i), 32'(hold_o), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
    end
    changes = 0;
    prev = led[7];
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'h0);
      if (led[7] !== prev) changes++;
      prev = led[7];
    end
    chk("blink_toggles", 32'(changes), 32'd4);
    step(1'b0, 4'h1);
    step(1'b0, 4'h0);
    chk("hold_next_granted", 32'(grant), 32'h1);
    idle(3);
    chk("hold_state_frozen", 32'(state_o), 32'h1);
    step(1'b0, 4'h8);
    idle(4);
    chk("unhold_flag", 32'(hold_o), 32'h0);
    chk("unhold_led7", 32'(led[7]), 32'h0);
    step(1'b1, 4'h0);
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 4'h1);
      idle(3);
      chk($sformatf("next_seq%0d", n), 32'(state_o), 32'(nseq[n]));
    end
    step(1'b0, 4'h2);
    idle(3);
    chk("prev_state", 32'(state_o), 32'h8);
    chk("prev_led", 32'(led), 32'h04);
    step(1'b1, 4'h0);
    step(1'b0, 4'h6);
    step(1'b0, 4'h1);
    step(1'b0, 4'h1);
    idle(5);
    chk("drop_one_next", 32'(state_o), 32'h2);
`ifdef KEY_SCHED_DROP_CNT_EN
    chk("drop_cnt_one", 32'(drop_cnt), 32'h1);
`endif
    step(1'b1, 4'h0);
    step(1'b0, 4'h1);
    idle(3);
    step(1'b0, 4'h1);
    idle(3);
    chk("pre_rst_state", 32'(state_o), 32'h4);
    step(1'b0, 4'hB);
    step(1'b1, 4'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_state", 32'(state_o), 32'h1);
    chk("rst_led", 32'(led), 32'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0);
      chk($sformatf("rst_no_grant%0d", i), 32'(grant), 32'h0);
    end
    for (int i = 0; i < 400; i++) begin
      logic [3:0] kf;
      for (int b = 0; b < 4; b++) kf[b] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) == 0, kf);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
